// File: rtl/edge_event_detector.sv
// edge_event_detector
//
// Multi-channel edge/event detector for asynchronous pins such as a UART RX
// line, buttons or external strobes. Each channel passes its pin through a
// synchroniser, then a glitch filter, then an edge qualifier selected per
// channel. The outputs are a one-cycle event pulse and a sticky status flag
// that is cleared by writing 1.
//
// Optional feature: when the macro EDGE_EVENT_COUNT_EN is defined, each
// channel also has a saturating event counter. When the macro is not
// defined, Edge_Count is tied to zero. The port is present in both builds,
// so instantiations do not change.
//
// Ports
//   Clk          in   system clock; all logic runs on its rising edge
//   Rst_n        in   asynchronous active-low reset
//   En           in   global enable for event generation (does not affect
//                     level tracking)
//   Signal_In    in   [NUM_CH] raw asynchronous inputs
//   Mode         in   [2*NUM_CH] per-channel mode, bits [2i+1:2i]:
//                     00 off, 01 rise, 10 fall, 11 both
//   Status_Clr   in   [NUM_CH] per-channel clear strobe for the status flag
//                     (and for the counter, when present)
//   Level_Out    out  [NUM_CH] filtered, synchronised level
//   Edge_Pulse   out  [NUM_CH] registered one-cycle event pulse
//   Edge_Status  out  [NUM_CH] sticky event flags
//   Any_Event    out  OR of Edge_Status (combinational)
//   Edge_Count   out  [NUM_CH*CNT_W] event count; channel i is at
//                     [CNT_W*i +: CNT_W]
module edge_event_detector #(
  parameter int NUM_CH        = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3,
  parameter bit INIT_LEVEL    = 1'b1,
  parameter int CNT_W         = 8
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic                      En,
  input  logic [NUM_CH-1:0]         Signal_In,
  input  logic [2*NUM_CH-1:0]       Mode,
  input  logic [NUM_CH-1:0]         Status_Clr,
  output logic [NUM_CH-1:0]         Level_Out,
  output logic [NUM_CH-1:0]         Edge_Pulse,
  output logic [NUM_CH-1:0]         Edge_Status,
  output logic                      Any_Event,
  output logic [NUM_CH*CNT_W-1:0]   Edge_Count
);

  localparam int FLT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_CYCLES - 1);

  for (genvar i = 0; i < NUM_CH; i++) begin : gCh
    logic [SYNC_STAGES-1:0] syncQ;
    logic [FLT_W-1:0]       fltCnt;
    logic                   levelQ;
    logic                   pulseQ;
    logic                   statusQ;
    logic                   syncLvl;
    logic                   fltDone;
    logic                   evt;

    assign syncLvl = syncQ[SYNC_STAGES-1];

    // The filtered level flips on this edge.
    assign fltDone = (syncLvl != levelQ) && (fltCnt == FLT_LAST);

    // If the level flips now, its new value is syncLvl. So syncLvl=1 means
    // a rise and syncLvl=0 means a fall.
    assign evt = En & fltDone & (syncLvl ? Mode[2*i] : Mode[2*i+1]);

    // The synchroniser runs all the time, whatever En is.
    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        syncQ <= {SYNC_STAGES{INIT_LEVEL}};
      end else begin
        syncQ <= {syncQ[SYNC_STAGES-2:0], Signal_In[i]};
      end
    end

    // Glitch filter. The level changes only after FILTER_CYCLES consecutive
    // synchronised samples disagree with it. Any agreeing sample restarts
    // the count.
    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        fltCnt <= '0;
        levelQ <= INIT_LEVEL;
      end else if (syncLvl == levelQ) begin
        fltCnt <= '0;
      end else if (fltCnt == FLT_LAST) begin
        fltCnt <= '0;
        levelQ <= syncLvl;
      end else begin
        fltCnt <= fltCnt + FLT_W'(1);
      end
    end

    // If a clear and an event land on the same edge, the status stays set.
    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        pulseQ  <= 1'b0;
        statusQ <= 1'b0;
      end else begin
        pulseQ  <= evt;
        statusQ <= evt | (statusQ & ~Status_Clr[i]);
      end
    end

    assign Level_Out[i]   = levelQ;
    assign Edge_Pulse[i]  = pulseQ;
    assign Edge_Status[i] = statusQ;

`ifdef EDGE_EVENT_COUNT_EN
    logic [CNT_W-1:0] cntQ;

    // Saturating counter. A clear on the same edge as an event loads 1,
    // so that event is still counted.
    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        cntQ <= '0;
      end else if (Status_Clr[i]) begin
        cntQ <= evt ? CNT_W'(1) : '0;
      end else if (evt && (cntQ != {CNT_W{1'b1}})) begin
        cntQ <= cntQ + CNT_W'(1);
      end
    end

    assign Edge_Count[CNT_W*i +: CNT_W] = cntQ;
`endif
  end

`ifndef EDGE_EVENT_COUNT_EN
  assign Edge_Count = '0;
`endif

  assign Any_Event = |Edge_Status;

endmodule

// File: tb/tb_edge_event_detector.sv
// Testbench for edge_event_detector.
//
// A reference model checks the DUT on every clock. The model describes the
// filter as a sliding window over the raw input history: the filtered level
// flips when the FILTER_CYCLES samples that are SYNC_STAGES cycles old all
// differ from the current level. Directed scenarios come first, then a
// randomized phase.
module tb_edge_event_detector;

  localparam int NUM_CH        = 4;
  localparam int SYNC_STAGES   = 2;
  localparam int FILTER_CYCLES = 3;
  localparam bit INIT_LEVEL    = 1'b1;
  localparam int CNT_W         = 2;
  localparam int LAT           = SYNC_STAGES + FILTER_CYCLES;
  localparam int CW_ALL        = NUM_CH * CNT_W;
  localparam int W             = 3 * NUM_CH + 1 + CW_ALL;

  logic                    Clk;
  logic                    Rst_n;
  logic                    En;
  logic [NUM_CH-1:0]       Signal_In;
  logic [2*NUM_CH-1:0]     Mode;
  logic [NUM_CH-1:0]       Status_Clr;
  logic [NUM_CH-1:0]       Level_Out;
  logic [NUM_CH-1:0]       Edge_Pulse;
  logic [NUM_CH-1:0]       Edge_Status;
  logic                    Any_Event;
  logic [CW_ALL-1:0]       Edge_Count;

  edge_event_detector #(
    .NUM_CH       (NUM_CH),
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES),
    .INIT_LEVEL   (INIT_LEVEL),
    .CNT_W        (CNT_W)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .En         (En),
    .Signal_In  (Signal_In),
    .Mode       (Mode),
    .Status_Clr (Status_Clr),
    .Level_Out  (Level_Out),
    .Edge_Pulse (Edge_Pulse),
    .Edge_Status(Edge_Status),
    .Any_Event  (Any_Event),
    .Edge_Count (Edge_Count)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- check task and counters ----------------
  int nChecks = 0;
  int nPass   = 0;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [NUM_CH-1:0] mLevel;
  logic [NUM_CH-1:0] mPulse;
  logic [NUM_CH-1:0] mStatus;
  logic [CNT_W-1:0]  mCnt [NUM_CH];
  logic [NUM_CH-1:0] hist [$];
  logic [W-1:0]      exp_q [$];
  int                pulseSeen [NUM_CH];

  task automatic modelReset();
    mLevel  = {NUM_CH{INIT_LEVEL}};
    mPulse  = '0;
    mStatus = '0;
    for (int c = 0; c < NUM_CH; c++) mCnt[c] = '0;
    hist.delete();
    for (int k = 0; k < LAT - 1; k++) hist.push_back({NUM_CH{INIT_LEVEL}});
  endtask

  task automatic modelStep();
    logic [NUM_CH-1:0] s;
    bit allDiff;
    bit ev;
    bit rise;
    hist.push_back(Signal_In);
    while (hist.size() > LAT) void'(hist.pop_front());
    // hist[0..FILTER_CYCLES-1] are the samples the filter sees, oldest first.
    for (int c = 0; c < NUM_CH; c++) begin
      allDiff = 1'b1;
      for (int k = 0; k < FILTER_CYCLES; k++) begin
        s = hist[k];
        if (s[c] == mLevel[c]) allDiff = 1'b0;
      end
      ev = 1'b0;
      if (allDiff) begin
        rise = (mLevel[c] == 1'b0);
        ev = En && (rise ? Mode[2*c] : Mode[2*c+1]);
        mLevel[c] = ~mLevel[c];
      end
      mPulse[c]  = ev;
      mStatus[c] = ev | (mStatus[c] & ~Status_Clr[c]);
      if (Status_Clr[c]) mCnt[c] = ev ? CNT_W'(1) : '0;
      else if (ev && mCnt[c] != {CNT_W{1'b1}}) mCnt[c] = mCnt[c] + CNT_W'(1);
    end
  endtask

  function automatic logic [W-1:0] packExp();
    logic [CW_ALL-1:0] cv;
    cv = '0;
`ifdef EDGE_EVENT_COUNT_EN
    for (int c = 0; c < NUM_CH; c++) cv[CNT_W*c +: CNT_W] = mCnt[c];
`endif
    return {mLevel, mPulse, mStatus, |mStatus, cv};
  endfunction

  task automatic compareOutputs();
    logic [W-1:0] e;
    e = exp_q.pop_front();
    checkEq("level",  64'(Level_Out),   64'(e[W-1 -: NUM_CH]));
    checkEq("pulse",  64'(Edge_Pulse),  64'(e[W-1-NUM_CH -: NUM_CH]));
    checkEq("status", 64'(Edge_Status), 64'(e[W-1-2*NUM_CH -: NUM_CH]));
    checkEq("any",    64'(Any_Event),   64'(e[CW_ALL]));
    checkEq("count",  64'(Edge_Count),  64'(e[CW_ALL-1:0]));
    for (int c = 0; c < NUM_CH; c++) pulseSeen[c] += int'(Edge_Pulse[c]);
  endtask

  // Scoreboard. The model advances on each active edge, and the DUT is
  // compared 1 time unit later.
  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      modelReset();
    end else begin
      modelStep();
      exp_q.push_back(packExp());
      #1;
      compareOutputs();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic applyReset();
    @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    checkEq("rst_level",  64'(Level_Out),   64'({NUM_CH{INIT_LEVEL}}));
    checkEq("rst_pulse",  64'(Edge_Pulse),  64'(0));
    checkEq("rst_status", 64'(Edge_Status), 64'(0));
    checkEq("rst_any",    64'(Any_Event),   64'(0));
    checkEq("rst_count",  64'(Edge_Count),  64'(0));
    tick(2);
    Rst_n = 1'b1;
  endtask

  task automatic clearAll();
    Status_Clr = '1;
    tick(1);
    Status_Clr = '0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus ----------------
  initial begin
    int base;
    for (int c = 0; c < NUM_CH; c++) pulseSeen[c] = 0;
    modelReset();
    Rst_n      = 1'b0;
    En         = 1'b0;
    Signal_In  = '1;
    Mode       = '0;
    Status_Clr = '0;
    tick(2);
    applyReset();

    // 1: idle-high inputs after reset release give no events
    tick(20);
    checkEq("idle_level", 64'(Level_Out), 64'(4'hF));
    checkEq("idle_any",   64'(Any_Event), 64'(0));
    checkEq("idle_pulses", 64'(pulseSeen[0] + pulseSeen[1] + pulseSeen[2] + pulseSeen[3]), 64'(0));

    // 2: ch0 rise-only; the pulse appears after edge LAT of the rising input
    En   = 1'b1;
    Mode = 8'b00_00_00_01;
    Signal_In[0] = 1'b0;
    tick(10);
    Signal_In[0] = 1'b1;
    repeat (LAT - 1) @(posedge Clk);
    #1;
    checkEq("ch0_pulse_early", 64'(Edge_Pulse), 64'(0));
    @(posedge Clk);
    #1;
    checkEq("ch0_pulse_edge", 64'(Edge_Pulse), 64'(4'b0001));
    tick(10);
    checkEq("ch0_status", 64'(Edge_Status), 64'(4'b0001));
    checkEq("ch0_any",    64'(Any_Event),   64'(1));

    // 3: ch1 both edges; a 2-cycle glitch is filtered, a 6-cycle low is not
    clearAll();
    Mode = 8'b00_00_11_00;
    base = pulseSeen[1];
    Signal_In[1] = 1'b0;
    tick(2);
    Signal_In[1] = 1'b1;
    tick(10);
    checkEq("ch1_glitch_level",  64'(Level_Out[1]),   64'(1));
    checkEq("ch1_glitch_pulses", 64'(pulseSeen[1] - base), 64'(0));
    Signal_In[1] = 1'b0;
    tick(6);
    Signal_In[1] = 1'b1;
    tick(10);
    checkEq("ch1_two_pulses", 64'(pulseSeen[1] - base), 64'(2));
    checkEq("ch1_status",     64'(Edge_Status[1]),      64'(1));

    // 4: ch2 fall while En is low; the level follows but no event is raised
    Mode = 8'b00_10_00_00;
    En   = 1'b0;
    Signal_In[2] = 1'b0;
    tick(LAT + 2);
    checkEq("ch2_level",     64'(Level_Out[2]),   64'(0));
    checkEq("ch2_status_en0", 64'(Edge_Status[2]), 64'(0));
    En = 1'b1;
    tick(10);
    checkEq("ch2_status_en1", 64'(Edge_Status[2]), 64'(0));
    checkEq("ch2_pulses",     64'(pulseSeen[2]),   64'(0));
    Signal_In[2] = 1'b1;
    tick(10);

    // 5: ch3 event and clear on the same edge; the set wins
    clearAll();
    Mode = 8'b11_00_00_00;
    Signal_In[3] = 1'b0;
    repeat (LAT - 1) @(negedge Clk);
    Status_Clr[3] = 1'b1;
    @(negedge Clk);
    Status_Clr = '0;
    checkEq("ch3_set_wins", 64'(Edge_Status[3]), 64'(1));
    tick(3);
    Status_Clr[3] = 1'b1;
    tick(1);
    Status_Clr = '0;
    checkEq("ch3_cleared", 64'(Edge_Status[3]), 64'(0));
    Signal_In[3] = 1'b1;
    tick(10);

`ifdef EDGE_EVENT_COUNT_EN
    // 6: counter saturation on ch0, then a clear that coincides with an event
    clearAll();
    Mode = 8'b00_00_00_01;
    for (int k = 0; k < 5; k++) begin
      Signal_In[0] = 1'b0;
      tick(8);
      Signal_In[0] = 1'b1;
      tick(8);
    end
    checkEq("cnt_saturated", 64'(Edge_Count[CNT_W-1:0]), 64'(3));
    Signal_In[0] = 1'b0;
    tick(8);
    Signal_In[0] = 1'b1;
    repeat (LAT - 1) @(negedge Clk);
    Status_Clr[0] = 1'b1;
    @(negedge Clk);
    Status_Clr = '0;
    checkEq("cnt_clr_event", 64'(Edge_Count[CNT_W-1:0]), 64'(1));
    tick(5);
`endif

    // 7: randomized traffic, checked by the scoreboard on every cycle
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 49) == 0) Mode = 8'($urandom);
      En = ($urandom_range(0, 4) != 0);
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 5) == 0) Signal_In[c] = ~Signal_In[c];
        Status_Clr[c] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 399) == 0) begin
        Status_Clr = '0;
        applyReset();
      end else begin
        tick(1);
      end
    end
    Status_Clr = '0;
    tick(5);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
